// File: rtl/fp32_pkg.sv
// Shared IEEE-754 single-precision constants, FSM state type and field helpers
// used by the floating-point arithmetic blocks.
package fp32_pkg;

  localparam int         BIAS      = 127;
  localparam logic [7:0] EXP_MAX   = 8'hFF;
  localparam int         DIV_ITERS = 26;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    NORM = 2'd2
  } state_t;

  function automatic logic f_sign(input logic [31:0] x);
    return x[31];
  endfunction

  function automatic logic [7:0] f_exp(input logic [31:0] x);
    return x[30:23];
  endfunction

  function automatic logic [22:0] f_mant(input logic [31:0] x);
    return x[22:0];
  endfunction

endpackage

// File: rtl/fp_div_step.sv
// One combinational restoring-division step: trial subtract, keep or restore,
// then shift the partial remainder left for the next quotient bit.
module fp_div_step (
  input  logic [24:0] rem,
  input  logic [23:0] mb,
  output logic [24:0] rem_next,
  output logic        q_bit
);

  logic [24:0] diff;

  always_comb begin
    q_bit    = (rem >= {1'b0, mb});
    diff     = q_bit ? (rem - {1'b0, mb}) : rem;
    // A kept remainder is always below mb < 2^24, so bit 24 is never live.
    rem_next = {diff[23:0], 1'b0};
  end

endmodule

// File: rtl/fp_divider_seq.sv
// Sequential IEEE-754 single-precision divider: 26 restoring iterations, one
// normalise/round cycle, fixed 27-cycle latency for every operand pair.
module fp_divider_seq
  import fp32_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        exception,
  output logic        div_by_zero,
  output logic        overflow,
  output logic        underflow
);

  localparam logic [4:0]        LAST_ITER = 5'(DIV_ITERS - 1);
  localparam logic signed [9:0] BIAS_W    = 10'(BIAS);

  state_t      state, state_nxt;
  logic [4:0]  cnt;
  logic [24:0] rem, rem_nxt;
  logic [25:0] q;
  logic        q_bit;
  logic        sign, exc, a_zero, b_zero;
  logic [7:0]  ea, eb;
  logic [23:0] mb;

  logic signed [9:0] exp_base, exp_pre, exp_fin;
  logic [22:0] mant_pre;
  logic        guard, sticky, ovf, unf;
  logic [23:0] mant_rnd;
  logic [31:0] res_nxt;
  logic [3:0]  flags_nxt;

  function automatic logic [23:0] round_mant(input logic [22:0] m, input logic g,
                                             input logic s);
    return {1'b0, m} + {23'd0, g & s};
  endfunction

  function automatic logic [23:0] flush_mant(input logic [31:0] x);
    return (f_exp(x) == 8'd0) ? 24'd0 : {1'b1, f_mant(x)};
  endfunction

  fp_div_step u_step (
    .rem      (rem),
    .mb       (mb),
    .rem_next (rem_nxt),
    .q_bit    (q_bit)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = DIV;
      DIV:     if (cnt == LAST_ITER) state_nxt = NORM;
      NORM:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // Normalise and round from the finished quotient; consumed only in NORM.
  always_comb begin
    exp_base = $signed({2'b00, ea}) - $signed({2'b00, eb});
    if (q[25]) begin
      mant_pre = q[24:2];
      guard    = q[1];
      sticky   = q[0] | (|rem);
      exp_pre  = exp_base + BIAS_W;
    end else begin
      mant_pre = q[23:1];
      guard    = q[0];
      sticky   = |rem;
      exp_pre  = exp_base + BIAS_W - 10'sd1;
    end
    mant_rnd = round_mant(mant_pre, guard, sticky);
    // A rounding carry leaves mant_rnd[22:0] all zero, so only exp moves.
    exp_fin  = exp_pre + $signed({9'd0, mant_rnd[23]});
    ovf      = (exp_fin >= 10'sd255);
    unf      = (exp_fin <= 10'sd0);

    res_nxt   = {sign, exp_fin[7:0], mant_rnd[22:0]};
    flags_nxt = 4'b0000;
    if (exc) begin
      res_nxt   = 32'h0;
      flags_nxt = 4'b1000;
    end else if (b_zero) begin
      res_nxt   = {sign, EXP_MAX, 23'h0};
      flags_nxt = 4'b0100;
    end else if (a_zero) begin
      res_nxt   = {sign, 31'h0};
    end else if (ovf) begin
      res_nxt   = {sign, EXP_MAX, 23'h0};
      flags_nxt = 4'b0010;
    end else if (unf) begin
      res_nxt   = {sign, 31'h0};
      flags_nxt = 4'b0001;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      done        <= 1'b0;
      result      <= 32'h0;
      exception   <= 1'b0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
      underflow   <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= (state == NORM);
      if (state == NORM) begin
        result <= res_nxt;
        {exception, div_by_zero, overflow, underflow} <= flags_nxt;
      end
    end
  end

  // Operand capture and iteration datapath
  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      sign   <= f_sign(a) ^ f_sign(b);
      ea     <= f_exp(a);
      eb     <= f_exp(b);
      mb     <= flush_mant(b);
      a_zero <= (f_exp(a) == 8'd0);
      b_zero <= (f_exp(b) == 8'd0);
      exc    <= (f_exp(a) == EXP_MAX) || (f_exp(b) == EXP_MAX);
      rem    <= {1'b0, flush_mant(a)};
      q      <= 26'd0;
      cnt    <= 5'd0;
    end else if (state == DIV) begin
      rem <= rem_nxt;
      q   <= {q[24:0], q_bit};
      cnt <= cnt + 5'd1;
    end
  end

endmodule

// File: tb/tb_fp_divider_seq.sv
// Directed-vector bench for fp_divider_seq: timing, rounding, special cases,
// range limits, start filtering, back-to-back issue and mid-operation reset.
module tb_fp_divider_seq;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [31:0] a, b;
  logic        busy, done;
  logic [31:0] result;
  logic        exception, div_by_zero, overflow, underflow;

  int vectors = 0;
  int errors  = 0;

  fp_divider_seq dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .result      (result),
    .exception   (exception),
    .div_by_zero (div_by_zero),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  always #5 clk = ~clk;

  // Issues one operation and returns the done latency in edges after the
  // accepting edge (-1 if none within 40), plus whether busy stayed high
  // from edge 0 up to the done edge and dropped on it.
  task automatic run_op(input logic [31:0] ia, input logic [31:0] ib,
                        output int lat, output logic busy_ok);
    @(negedge clk);
    a = ia; b = ib; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = $urandom; b = $urandom;
    busy_ok = busy;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = k;
        if (busy) busy_ok = 1'b0;
        break;
      end
      if (!busy) busy_ok = 1'b0;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b1; a = 32'h40C00000; b = 32'h40000000;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({busy, done} !== 2'b00) begin
      errors++; $display("FAIL reset_ctrl: busy/done=%b expected 00", {busy, done});
    end
    vectors++;
    if (result !== 32'h0) begin
      errors++; $display("FAIL reset_result: got %h expected 00000000", result);
    end
    vectors++;
    if ({exception, div_by_zero, overflow, underflow} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags: got %b expected 0000",
                         {exception, div_by_zero, overflow, underflow});
    end
    start = 1'b0;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_basic;
    int lat; logic bok;
    run_op(32'h40C00000, 32'h40000000, lat, bok);
    vectors++;
    if (lat !== 27) begin
      errors++; $display("FAIL basic_latency: got %0d expected 27", lat);
    end
    vectors++;
    if (bok !== 1'b1) begin
      errors++; $display("FAIL basic_busy: busy profile wrong, got %b expected 1", bok);
    end
    vectors++;
    if (result !== 32'h40400000) begin
      errors++; $display("FAIL basic_result: got %h expected 40400000", result);
    end
    vectors++;
    if ({exception, div_by_zero, overflow, underflow} !== 4'b0000) begin
      errors++; $display("FAIL basic_flags: got %b expected 0000",
                         {exception, div_by_zero, overflow, underflow});
    end
    @(posedge clk); #1;
    vectors++;
    if ({done, result} !== {1'b0, 32'h40400000}) begin
      errors++; $display("FAIL basic_hold: done=%b result=%h expected 0 40400000", done, result);
    end
  endtask

  task automatic test_values;
    logic [31:0] va [6];
    logic [31:0] vb [6];
    logic [31:0] vr [6];
    logic [3:0]  vf [6];
    int lat; logic bok;
    va[0] = 32'h3F800000; vb[0] = 32'h40400000; vr[0] = 32'h3EAAAAAB; vf[0] = 4'b0000;
    va[1] = 32'h3F800000; vb[1] = 32'h3F800000; vr[1] = 32'h3F800000; vf[1] = 4'b0000;
    va[2] = 32'hC0C00000; vb[2] = 32'h40000000; vr[2] = 32'hC0400000; vf[2] = 4'b0000;
    va[3] = 32'h80000000; vb[3] = 32'h40000000; vr[3] = 32'h80000000; vf[3] = 4'b0000;
    va[4] = 32'h00400000; vb[4] = 32'h3F800000; vr[4] = 32'h00000000; vf[4] = 4'b0000;
    va[5] = 32'h3F800000; vb[5] = 32'hC0000000; vr[5] = 32'hBF000000; vf[5] = 4'b0000;
    for (int i = 0; i < 6; i++) begin
      run_op(va[i], vb[i], lat, bok);
      vectors++;
      if ({lat == 27, result, exception, div_by_zero, overflow, underflow} !==
          {1'b1, vr[i], vf[i]}) begin
        errors++;
        $display("FAIL value_%0d: lat=%0d result=%h flags=%b expected lat=27 %h %b", i, lat,
                 result, {exception, div_by_zero, overflow, underflow}, vr[i], vf[i]);
      end
    end
  endtask

  task automatic test_special;
    logic [31:0] va [4];
    logic [31:0] vb [4];
    logic [31:0] vr [4];
    logic [3:0]  vf [4];
    int lat; logic bok;
    va[0] = 32'hBF800000; vb[0] = 32'h00000000; vr[0] = 32'hFF800000; vf[0] = 4'b0100;
    va[1] = 32'h7F800000; vb[1] = 32'h3F800000; vr[1] = 32'h00000000; vf[1] = 4'b1000;
    va[2] = 32'h7F000000; vb[2] = 32'h3F000000; vr[2] = 32'h7F800000; vf[2] = 4'b0010;
    va[3] = 32'h00800000; vb[3] = 32'h40000000; vr[3] = 32'h00000000; vf[3] = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      run_op(va[i], vb[i], lat, bok);
      vectors++;
      if ({lat == 27, bok, result, exception, div_by_zero, overflow, underflow} !==
          {2'b11, vr[i], vf[i]}) begin
        errors++;
        $display("FAIL special_%0d: lat=%0d busy_ok=%b result=%h flags=%b expected lat=27 1 %h %b",
                 i, lat, bok, result, {exception, div_by_zero, overflow, underflow},
                 vr[i], vf[i]);
      end
    end
  endtask

  task automatic test_ignore_start;
    int lat;
    @(negedge clk);
    a = 32'h40C00000; b = 32'h40000000; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      start = (k == 5 || k == 12);
      a = 32'h3F800000; b = 32'h40400000;
      @(posedge clk); #1;
      start = 1'b0;
      if (done) begin lat = k; break; end
    end
    vectors++;
    if ({lat == 27, result} !== {1'b1, 32'h40400000}) begin
      errors++; $display("FAIL ignore_start: lat=%0d result=%h expected 27 40400000", lat, result);
    end
    @(posedge clk); #1;
    vectors++;
    if ({busy, done} !== 2'b00) begin
      errors++; $display("FAIL ignore_start_idle: busy/done=%b expected 00", {busy, done});
    end
  endtask

  task automatic test_back_to_back;
    int lat, gap; logic bok;
    run_op(32'h40C00000, 32'h40000000, lat, bok);
    a = 32'h3F800000; b = 32'h40400000; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = 32'h0; b = 32'h0;
    gap = -1;
    vectors++;
    if ({busy, done, result} !== {2'b10, 32'h40400000}) begin
      errors++; $display("FAIL b2b_accept: busy=%b done=%b result=%h expected 1 0 40400000",
                         busy, done, result);
    end
    for (int k = 2; k <= 40; k++) begin
      @(posedge clk); #1;
      if (done) begin gap = k; break; end
    end
    vectors++;
    if ({gap == 28, result} !== {1'b1, 32'h3EAAAAAB}) begin
      errors++; $display("FAIL b2b_second: gap=%0d result=%h expected 28 3EAAAAAB", gap, result);
    end
  endtask

  task automatic test_rst_mid;
    int lat; logic bok; logic saw_done;
    @(negedge clk);
    a = 32'h40C00000; b = 32'h40000000; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1; rst = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if ({busy, done, result} !== {2'b00, 32'h0}) begin
      errors++; $display("FAIL rst_mid_abort: busy=%b done=%b result=%h expected 0 0 00000000",
                         busy, done, result);
    end
    rst = 1'b0;
    saw_done = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      if (done || busy) saw_done = 1'b1;
    end
    vectors++;
    if (saw_done !== 1'b0) begin
      errors++; $display("FAIL rst_mid_quiet: activity=%b expected 0", saw_done);
    end
    run_op(32'h3F800000, 32'h40400000, lat, bok);
    vectors++;
    if ({lat == 27, bok, result} !== {2'b11, 32'h3EAAAAAB}) begin
      errors++; $display("FAIL rst_mid_next: lat=%0d busy_ok=%b result=%h expected 27 1 3EAAAAAB",
                         lat, bok, result);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; a = 32'h0; b = 32'h0;
    test_reset;
    test_basic;
    test_values;
    test_special;
    test_ignore_start;
    test_back_to_back;
    test_rst_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
